// File: rtl/mapper_framer_if.sv
// Payload-in / line-out handshake bundle for mapper_framer.
// The master modport is the framer side; the slave modport is the client and transmitter side.
interface mapper_framer_if;
  logic [7:0] i_pyld_data;
  logic       i_pyld_data_valid;
  logic       o_pyld_data_ready;
  logic [7:0] o_frame_data;
  logic       o_frame_data_valid;
  logic       o_frame_data_fas;
  logic       i_frame_data_ready;

  modport master (
    input  i_pyld_data,
    input  i_pyld_data_valid,
    input  i_frame_data_ready,
    output o_pyld_data_ready,
    output o_frame_data,
    output o_frame_data_valid,
    output o_frame_data_fas
  );

  modport slave (
    output i_pyld_data,
    output i_pyld_data_valid,
    output i_frame_data_ready,
    input  o_pyld_data_ready,
    input  o_frame_data,
    input  o_frame_data_valid,
    input  o_frame_data_fas
  );
endinterface

// File: rtl/mapper_framer.sv
// Builds 4 x NUM_COLS byte frames: FAS0/FAS1, OH (ARQ), zero byte, client payload, trailing CRC-8.
// A single output register stage feeds the serial transmitter with valid/ready flow control.
module mapper_framer #(
  parameter int unsigned NUM_COLS = 1024,
  parameter logic [7:0]  FAS0     = 8'hF6,
  parameter logic [7:0]  FAS1     = 8'h28
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_en,
  input  logic            i_arq_en,
  input  logic            i_arq_en_valid,
  output logic [7:0]      o_crc_val,
  mapper_framer_if.master bus
);

  localparam int unsigned COL_W = 11;
  localparam int unsigned ROW_W = 2;
  localparam logic [COL_W-1:0] LAST_COL      = COL_W'(NUM_COLS - 1);
  localparam logic [COL_W-1:0] LAST_PYLD_COL = COL_W'(NUM_COLS - 2);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_FAS  = 3'd1,
    ST_OH   = 3'd2,
    ST_PYLD = 3'd3,
    ST_CRC  = 3'd4
  } state_t;

  state_t           r_state, w_state;
  logic [ROW_W-1:0] r_row, w_row, w_row_step;
  logic [COL_W-1:0] r_col, w_col, w_col_step;
  logic             r_arq, w_arq;
  logic [7:0]       r_crc, w_crc;
  logic [7:0]       r_data, w_data;
  logic             r_valid, w_valid;
  logic             r_fas, w_fas;
  logic [7:0]       r_crc_val, w_crc_val;
  logic             w_load;

  // CRC-8 poly 0x07, MSB first, one byte per call
  function automatic logic [7:0] f_crc8(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int i = 0; i < 8; i++) begin
      r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
    end
    return r;
  endfunction

  assign w_load     = !r_valid || bus.i_frame_data_ready;
  assign w_col_step = (r_col == LAST_COL) ? '0 : r_col + COL_W'(1);
  assign w_row_step = (r_col == LAST_COL) ? r_row + ROW_W'(1) : r_row;

  assign bus.o_pyld_data_ready  = (r_state == ST_PYLD) && w_load;
  assign bus.o_frame_data       = r_data;
  assign bus.o_frame_data_valid = r_valid;
  assign bus.o_frame_data_fas   = r_fas;
  assign o_crc_val              = r_crc_val;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_row     <= '0;
      r_col     <= '0;
      r_arq     <= 1'b0;
      r_crc     <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_fas     <= 1'b0;
      r_crc_val <= '0;
    end else begin
      r_state   <= w_state;
      r_row     <= w_row;
      r_col     <= w_col;
      r_arq     <= w_arq;
      r_crc     <= w_crc;
      r_data    <= w_data;
      r_valid   <= w_valid;
      r_fas     <= w_fas;
      r_crc_val <= w_crc_val;
    end
  end

  always_comb begin
    w_state   = r_state;
    w_row     = r_row;
    w_col     = r_col;
    w_arq     = i_arq_en_valid ? i_arq_en : r_arq;
    w_crc     = r_crc;
    w_data    = r_data;
    w_valid   = r_valid;
    w_fas     = r_fas;
    w_crc_val = r_crc_val;

    // the output slot empties on every load unless a new byte refills it below
    if (w_load) begin
      w_valid = 1'b0;
      w_fas   = 1'b0;
    end

    case (r_state)
      ST_IDLE: begin
        if (i_en) w_state = ST_FAS;
      end
      ST_FAS: begin
        if (w_load) begin
          w_valid = 1'b1;
          w_crc   = '0;
          w_row   = w_row_step;
          w_col   = w_col_step;
          if (r_col == '0) begin
            w_data = FAS0;
            w_fas  = 1'b1;
          end else begin
            w_data  = FAS1;
            w_state = ST_OH;
          end
        end
      end
      ST_OH: begin
        if (w_load) begin
          w_valid = 1'b1;
          w_row   = w_row_step;
          w_col   = w_col_step;
          if (r_col == COL_W'(2)) begin
            w_data = {7'b0, r_arq};
            if (!i_arq_en_valid) w_arq = 1'b0;
          end else begin
            w_data  = 8'h00;
            w_state = ST_PYLD;
          end
        end
      end
      ST_PYLD: begin
        if (w_load && bus.i_pyld_data_valid) begin
          w_valid = 1'b1;
          w_data  = bus.i_pyld_data;
          w_crc   = f_crc8(r_crc, bus.i_pyld_data);
          w_row   = w_row_step;
          w_col   = w_col_step;
          if (r_row == ROW_W'(3) && r_col == LAST_PYLD_COL) w_state = ST_CRC;
        end
      end
      ST_CRC: begin
        // row 3 means the CRC byte is still to be sent; row 0 means it is draining before IDLE
        if (w_load) begin
          if (r_row == ROW_W'(3)) begin
            w_valid   = 1'b1;
            w_data    = r_crc;
            w_crc_val = r_crc;
            w_row     = w_row_step;
            w_col     = w_col_step;
            w_state   = i_en ? ST_FAS : ST_CRC;
          end else begin
            w_state = ST_IDLE;
          end
        end
      end
      default: w_state = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mapper_framer.sv
// Directed bench for mapper_framer with NUM_COLS = 8 (32-byte frames, 27 payload bytes).
module tb_mapper_framer;
  localparam int unsigned NC   = 8;
  localparam int          FLEN = 4 * NC;

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b0;
  logic       en      = 1'b0;
  logic       arq_en  = 1'b0;
  logic       arq_vld = 1'b0;
  logic [7:0] crc_val;

  mapper_framer_if bus ();

  mapper_framer #(.NUM_COLS(NC), .FAS0(8'hF6), .FAS1(8'h28)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_en           (en),
    .i_arq_en       (arq_en),
    .i_arq_en_valid (arq_vld),
    .o_crc_val      (crc_val),
    .bus            (bus)
  );

  always #5 clk = ~clk;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [8:0] cap[$];
  logic       pyld_take = 1'b0;
  logic       pyld_on   = 1'b0;
  logic       bp_on     = 1'b0;
  logic [7:0] pyld_val   = 8'd1;
  logic [7:0] pyld_start = 8'd1;
  logic [7:0] gap_at     = 8'd0;
  int         restart_req = 0, restart_seen = 0;
  int         gap_req = 0, gap_seen = 0, gap_cycle = 0;

  // capture line bytes that will be taken at the next rising edge
  always @(negedge clk) begin
    pyld_take = bus.i_pyld_data_valid && bus.o_pyld_data_ready;
    if (bus.o_frame_data_valid && bus.i_frame_data_ready)
      cap.push_back({bus.o_frame_data_fas, bus.o_frame_data});
  end

  // payload source and transmitter ready, updated just after each rising edge
  always @(posedge clk) begin
    #1;
    if (pyld_take) pyld_val = pyld_val + 8'd1;
    if (restart_req != restart_seen) begin
      restart_seen = restart_req;
      pyld_val     = pyld_start;
    end
    if (gap_cycle != 0) gap_cycle = (gap_cycle == 5) ? 0 : gap_cycle + 1;
    else if (gap_req != gap_seen && pyld_val == gap_at) begin
      gap_seen  = gap_req;
      gap_cycle = 1;
    end
    bus.i_pyld_data        = pyld_val;
    bus.i_pyld_data_valid  = pyld_on && (gap_cycle == 0);
    bus.i_frame_data_ready = bp_on ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  function automatic logic [7:0] crc_step(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    logic       fb;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      fb = r[7] ^ d[i];
      r  = {r[6:0], 1'b0};
      if (fb) r = r ^ 8'h07;
    end
    return r;
  endfunction

  function automatic logic [7:0] exp_crc(input logic [7:0] p0);
    logic [7:0] c;
    c = 8'h00;
    for (int k = 0; k < FLEN - 5; k++) c = crc_step(c, p0 + 8'(k));
    return c;
  endfunction

  // expected {fas, byte} at frame position i
  function automatic logic [8:0] exp_byte(input int i, input logic [7:0] p0, input logic arq);
    if (i == 0)        return {1'b1, 8'hF6};
    if (i == 1)        return {1'b0, 8'h28};
    if (i == 2)        return {1'b0, 7'b0, arq};
    if (i == 3)        return 9'h000;
    if (i == FLEN - 1) return {1'b0, exp_crc(p0)};
    return {1'b0, p0 + 8'(i - 4)};
  endfunction

  function automatic logic [8:0] cap_at(input int idx);
    if (idx < cap.size()) return cap[idx];
    return 9'h1FF;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++; if (bus.o_frame_data !== 8'h00) begin n_fail++; $display("FAIL rst_data got %h exp 00", bus.o_frame_data); end
    n_tests++; if (bus.o_frame_data_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b exp 0", bus.o_frame_data_valid); end
    n_tests++; if (bus.o_frame_data_fas !== 1'b0) begin n_fail++; $display("FAIL rst_fas got %b exp 0", bus.o_frame_data_fas); end
    n_tests++; if (bus.o_pyld_data_ready !== 1'b0) begin n_fail++; $display("FAIL rst_pready got %b exp 0", bus.o_pyld_data_ready); end
    n_tests++; if (crc_val !== 8'h00) begin n_fail++; $display("FAIL rst_crc got %h exp 00", crc_val); end
    #1 rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      n_tests++;
      if (bus.o_frame_data_valid !== 1'b0) begin n_fail++; $display("FAIL idle_valid cycle %0d got %b exp 0", c, bus.o_frame_data_valid); end
    end
  endtask

  task automatic test_basic();
    int off;
    off = cap.size();
    pyld_start = 8'd1; restart_req++; pyld_on = 1'b1;
    @(negedge clk); #1 en = 1'b1;
    for (int c = 0; c < 200 && cap.size() < off + 1; c++) @(negedge clk);
    #1 en = 1'b0;
    for (int c = 0; c < 200 && cap.size() < off + FLEN; c++) @(negedge clk);
    repeat (10) @(negedge clk);
    n_tests++; if (cap.size() != off + FLEN) begin n_fail++; $display("FAIL basic_len got %0d exp %0d", cap.size() - off, FLEN); end
    for (int i = 0; i < FLEN; i++) begin
      n_tests++;
      if (cap_at(off + i) !== exp_byte(i, 8'd1, 1'b0)) begin
        n_fail++; $display("FAIL basic_byte %0d got %h exp %h", i, cap_at(off + i), exp_byte(i, 8'd1, 1'b0));
      end
    end
    n_tests++; if (crc_val !== exp_crc(8'd1)) begin n_fail++; $display("FAIL basic_crc_val got %h exp %h", crc_val, exp_crc(8'd1)); end
    n_tests++; if (bus.o_frame_data_valid !== 1'b0) begin n_fail++; $display("FAIL basic_idle got %b exp 0", bus.o_frame_data_valid); end
  endtask

  task automatic test_backpressure();
    int         off;
    logic       prev_stall;
    logic [9:0] prev_word;
    off = cap.size(); prev_stall = 1'b0; prev_word = '0;
    pyld_start = 8'd1; restart_req++; bp_on = 1'b1;
    @(negedge clk); #1 en = 1'b1;
    for (int c = 0; c < 800 && cap.size() < off + FLEN + 1; c++) begin
      @(negedge clk);
      if (cap.size() > off) en = 1'b0;
      if (prev_stall) begin
        n_tests++;
        if ({bus.o_frame_data_valid, bus.o_frame_data_fas, bus.o_frame_data} !== prev_word) begin
          n_fail++; $display("FAIL bp_stall got %h exp %h", {bus.o_frame_data_valid, bus.o_frame_data_fas, bus.o_frame_data}, prev_word);
        end
      end
      prev_stall = bus.o_frame_data_valid && !bus.i_frame_data_ready;
      prev_word  = {bus.o_frame_data_valid, bus.o_frame_data_fas, bus.o_frame_data};
    end
    bp_on = 1'b0;
    n_tests++; if (cap.size() != off + FLEN) begin n_fail++; $display("FAIL bp_len got %0d exp %0d", cap.size() - off, FLEN); end
    for (int i = 0; i < FLEN; i++) begin
      n_tests++;
      if (cap_at(off + i) !== exp_byte(i, 8'd1, 1'b0)) begin
        n_fail++; $display("FAIL bp_byte %0d got %h exp %h", i, cap_at(off + i), exp_byte(i, 8'd1, 1'b0));
      end
    end
    n_tests++; if (crc_val !== exp_crc(8'd1)) begin n_fail++; $display("FAIL bp_crc_val got %h exp %h", crc_val, exp_crc(8'd1)); end
  endtask

  task automatic test_gap();
    int off, gap_checks;
    off = cap.size(); gap_checks = 0;
    pyld_start = 8'd1; restart_req++; gap_at = 8'd10; gap_req++;
    @(negedge clk); #1 en = 1'b1;
    for (int c = 0; c < 300 && cap.size() < off + FLEN; c++) begin
      @(negedge clk);
      if (cap.size() > off) en = 1'b0;
      if (gap_cycle >= 2) begin
        n_tests++; gap_checks++;
        if (bus.o_frame_data_valid !== 1'b0) begin n_fail++; $display("FAIL gap_valid gap cycle %0d got %b exp 0", gap_cycle, bus.o_frame_data_valid); end
      end
    end
    repeat (10) @(negedge clk);
    n_tests++; if (gap_checks != 4) begin n_fail++; $display("FAIL gap_seen got %0d exp 4", gap_checks); end
    n_tests++; if (cap.size() != off + FLEN) begin n_fail++; $display("FAIL gap_len got %0d exp %0d", cap.size() - off, FLEN); end
    for (int i = 0; i < FLEN; i++) begin
      n_tests++;
      if (cap_at(off + i) !== exp_byte(i, 8'd1, 1'b0)) begin
        n_fail++; $display("FAIL gap_byte %0d got %h exp %h", i, cap_at(off + i), exp_byte(i, 8'd1, 1'b0));
      end
    end
    n_tests++; if (crc_val !== exp_crc(8'd1)) begin n_fail++; $display("FAIL gap_crc_val got %h exp %h", crc_val, exp_crc(8'd1)); end
  endtask

  task automatic test_arq_back_to_back();
    int   off;
    logic seen_fas, pulsed;
    for (int part = 0; part < 2; part++) begin
      off = cap.size(); seen_fas = 1'b0; pulsed = 1'b0;
      pyld_start = 8'd1; restart_req++;
      @(negedge clk); #1 arq_en = 1'b1; arq_vld = 1'b1;
      @(negedge clk); #1 arq_en = 1'b0; arq_vld = 1'b0; en = 1'b1;
      for (int c = 0; c < 400 && cap.size() < off + 2 * FLEN; c++) begin
        @(negedge clk);
        if (part == 1 && !pulsed && seen_fas && bus.o_frame_data_valid && bus.o_frame_data == 8'h28) begin
          pulsed = 1'b1;
          #1 arq_en = 1'b1; arq_vld = 1'b1;
          @(negedge clk); #1 arq_en = 1'b0; arq_vld = 1'b0;
        end
        if (bus.o_frame_data_valid && bus.o_frame_data_fas) seen_fas = 1'b1;
        if (cap.size() > off + FLEN) en = 1'b0;
      end
      repeat (10) @(negedge clk);
      n_tests++; if (cap.size() != off + 2 * FLEN) begin n_fail++; $display("FAIL arq%0d_len got %0d exp %0d", part, cap.size() - off, 2 * FLEN); end
      for (int i = 0; i < 2 * FLEN; i++) begin
        logic [8:0] e;
        e = (i < FLEN) ? exp_byte(i, 8'd1, 1'b1) : exp_byte(i - FLEN, 8'd28, 1'(part));
        n_tests++;
        if (cap_at(off + i) !== e) begin
          n_fail++; $display("FAIL arq%0d_byte %0d got %h exp %h", part, i, cap_at(off + i), e);
        end
      end
      n_tests++; if (crc_val !== exp_crc(8'd28)) begin n_fail++; $display("FAIL arq%0d_crc_val got %h exp %h", part, crc_val, exp_crc(8'd28)); end
    end
  endtask

  task automatic test_en_drop();
    int off;
    off = cap.size();
    pyld_start = 8'd1; restart_req++;
    @(negedge clk); #1 en = 1'b1;
    for (int c = 0; c < 200 && cap.size() < off + 10; c++) @(negedge clk);
    #1 en = 1'b0;
    for (int c = 0; c < 200 && cap.size() < off + FLEN; c++) @(negedge clk);
    repeat (20) @(negedge clk);
    n_tests++; if (cap.size() != off + FLEN) begin n_fail++; $display("FAIL endrop_len got %0d exp %0d", cap.size() - off, FLEN); end
    for (int i = 0; i < FLEN; i++) begin
      n_tests++;
      if (cap_at(off + i) !== exp_byte(i, 8'd1, 1'b0)) begin
        n_fail++; $display("FAIL endrop_byte %0d got %h exp %h", i, cap_at(off + i), exp_byte(i, 8'd1, 1'b0));
      end
    end
    n_tests++; if (bus.o_frame_data_valid !== 1'b0) begin n_fail++; $display("FAIL endrop_idle got %b exp 0", bus.o_frame_data_valid); end
  endtask

  task automatic test_reset_mid();
    int off, cyc;
    off = cap.size();
    pyld_start = 8'd1; restart_req++;
    @(negedge clk); #1 en = 1'b1;
    for (int c = 0; c < 200 && cap.size() < off + 16; c++) @(negedge clk);
    n_tests++; if (bus.o_pyld_data_ready !== 1'b1) begin n_fail++; $display("FAIL mid_pready_pre got %b exp 1", bus.o_pyld_data_ready); end
    #1 rst_n = 1'b0;
    #1;
    n_tests++; if (bus.o_frame_data !== 8'h00) begin n_fail++; $display("FAIL mid_rst_data got %h exp 00", bus.o_frame_data); end
    n_tests++; if (bus.o_frame_data_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid got %b exp 0", bus.o_frame_data_valid); end
    n_tests++; if (bus.o_frame_data_fas !== 1'b0) begin n_fail++; $display("FAIL mid_rst_fas got %b exp 0", bus.o_frame_data_fas); end
    n_tests++; if (bus.o_pyld_data_ready !== 1'b0) begin n_fail++; $display("FAIL mid_rst_pready got %b exp 0", bus.o_pyld_data_ready); end
    n_tests++; if (crc_val !== 8'h00) begin n_fail++; $display("FAIL mid_rst_crc got %h exp 00", crc_val); end
    pyld_start = 8'd1; restart_req++;
    @(negedge clk); #1 rst_n = 1'b1;
    off = cap.size(); cyc = 0;
    while (cyc < 50 && !(bus.o_frame_data_valid && bus.o_frame_data_fas)) begin
      @(negedge clk); cyc++;
    end
    #1 en = 1'b0;
    n_tests++; if (cyc < 2 || cyc >= 50) begin n_fail++; $display("FAIL mid_first_fas got %0d cycles exp 2..49", cyc); end
    for (int c = 0; c < 200 && cap.size() < off + FLEN; c++) @(negedge clk);
    repeat (10) @(negedge clk);
    n_tests++; if (cap.size() != off + FLEN) begin n_fail++; $display("FAIL mid_len got %0d exp %0d", cap.size() - off, FLEN); end
    for (int i = 0; i < FLEN; i++) begin
      n_tests++;
      if (cap_at(off + i) !== exp_byte(i, 8'd1, 1'b0)) begin
        n_fail++; $display("FAIL mid_byte %0d got %h exp %h", i, cap_at(off + i), exp_byte(i, 8'd1, 1'b0));
      end
    end
    n_tests++; if (crc_val !== exp_crc(8'd1)) begin n_fail++; $display("FAIL mid_crc_val got %h exp %h", crc_val, exp_crc(8'd1)); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_gap();
    test_arq_back_to_back();
    test_en_drop();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired after %0t", $time);
    $fatal(1, "watchdog");
  end
endmodule
